red_filter_stream_core: RTL
===========================

Name: red_filter_stream_core

Overview:
AXI4-Stream pixel datapath controlled by the red_filter AXI4-Lite register slave. The slave's registers drive the cfg_* ports of this block. The block takes 0x00RRGGBB pixels from the upstream video DMA/source, applies the selected red-channel filter, and streams results downstream. It also reports per-frame statistics back into the register slave's readable registers.

Parameters:
DATA_WIDTH, 32, pixel/stream width; pixel format is [23:16]=R, [15:8]=G, [7:0]=B, [31:24] passed through as zero.
CNT_WIDTH, 24, width of the frame-size config and of the statistics counters.

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  DATA_WIDTH  input pixel
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when tvalid&tready
s_axis_tuser  in  1  start of frame (first pixel)
s_axis_tlast  in  1  last pixel of frame
m_axis_tdata  out  DATA_WIDTH  filtered pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tuser  out  1  start of frame, aligned with its pixel
m_axis_tlast  out  1  end of frame, aligned with its pixel
cfg_enable  in  1  0 = passthrough (mode ignored)
cfg_mode  in  2  00 pass, 01 red-only, 10 threshold, 11 dominance mask
cfg_threshold  in  8  red threshold
cfg_frame_pixels  in  CNT_WIDTH  expected pixels per frame
stat_red_count  out  CNT_WIDTH  red-qualifying pixels in last completed frame
stat_pixel_count  out  CNT_WIDTH  pixels counted in last completed frame
stat_frame_done  out  1  one-cycle pulse when a frame completes
stat_len_error  out  1  sticky; tlast position != cfg_frame_pixels

Behaviour:
- Reset (ARESETN low, async): all outputs 0; s_axis_tready 0 during reset, 1 from the first ACLK edge after release; state IDLE; shadow config 0; counters 0.
- Pipeline: single registered output stage, latency 1 cycle.
  - s_axis_tready = !m_axis_tvalid | m_axis_tready, giving full throughput of 1 beat/cycle.
  - m_axis_* hold stable while tvalid & !tready.
  - tuser/tlast are delayed with their pixel.
- Shadow config: cfg_enable/mode/threshold/frame_pixels are latched on the accepted beat carrying tuser. That beat and all beats up to tlast use the shadow values. Mid-frame cfg changes take effect only at the next frame.
- Filter (R,G,B from input; "qualifies" = counted in stat_red_count):
  - pass / enable=0: out = in & 0x00FFFFFF; qualifies if R>=thr.
  - red-only: out = {8'h0, R, 16'h0}; qualifies if R>=thr.
  - threshold: out = (R>=thr) ? {8'h0,R,16'h0} : 0.
  - mask: out = (R>=thr && R>G && R>B) ? 0x00FF0000 : 0; qualifies under the same condition.
  - Comparisons are unsigned 8-bit.
- FSM:
  - IDLE: beats without tuser are passed using the current shadow, are not counted, and stay in IDLE.
  - An accepted tuser beat moves to ACTIVE.
  - ACTIVE: a further tuser beat restarts counting (frame aborted, no frame_done) and sets stat_len_error.
  - An accepted tlast beat, including one with tuser=1 (single-pixel frame), returns to IDLE.
- Counters: pix_cnt and red_cnt include the current beat. Both saturate at all-ones with no wrap.
- On the accepted tlast beat:
  - stat_pixel_count/stat_red_count <= final counts.
  - stat_frame_done pulses on the next cycle.
  - If final pix_cnt != shadow frame_pixels, stat_len_error is set.
- stat_len_error clears only on reset or when an accepted tuser beat finds cfg_enable=0.
- tlast in IDLE without a prior tuser: pixel forwarded, no statistics update, stat_len_error set.
- Reset mid-frame: the output beat is dropped (tvalid=0) and the FSM returns to IDLE; the next frame must start with tuser.

Test Plan:
- Reset then mode=01, thr=0x80, frame_pixels=4; send 0x00FF1020,0x00402030,0x0090A0B0,0x00010203 (tuser first, tlast last) with m_tready=1 -> outputs 0x00FF0000,0x00400000,0x00900000,0x00010000 one cycle after each input; red_count=2, pixel_count=4, frame_done one pulse, len_error=0.
- Mode=11, thr=0x80, pixels 0x00FF1020, 0x0090A0B0, 0x0085FF00 -> 0x00FF0000, 0, 0; red_count=1.
- Backpressure: m_tready toggles 1,0,0,1 during a stream -> no beat lost or duplicated; m_tdata stable while stalled; s_tready low exactly when m_tvalid&!m_tready.
- frame_pixels=4 but tlast on the 3rd pixel -> pixel_count=3, len_error=1 and sticky across the next good frame; cleared by a tuser beat with cfg_enable=0.
- Change cfg_mode from 10 to 00 on the 2nd pixel of a frame -> all pixels of that frame use mode 10; the next frame passes through unchanged.
- Assert ARESETN low mid-frame after the 2nd pixel -> m_tvalid=0 and stats=0 immediately (async); a new 2-pixel frame afterwards gives pixel_count=2.

Source files
------------

// File: rtl/red_filter_stream_core.sv
// Red-channel filter for 0x00RRGGBB AXI4-Stream pixels: one registered output stage,
// frame-latched configuration and per-frame red/pixel statistics.
module red_filter_stream_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic [7:0]            cfg_threshold,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_pixels,
    output logic [CNT_WIDTH-1:0]  stat_red_count,
    output logic [CNT_WIDTH-1:0]  stat_pixel_count,
    output logic                  stat_frame_done,
    output logic                  stat_len_error
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic inc);
        if (inc && (cnt != CNT_MAX)) return cnt + CNT_WIDTH'(1);
        return cnt;
    endfunction

    state_t                 state_q;
    logic                   rdy_en_q;
    logic                   en_q;
    logic [1:0]             mode_q;
    logic [7:0]             thr_q;
    logic [CNT_WIDTH-1:0]   fp_q;
    logic [DATA_WIDTH-1:0]  m_data_q;
    logic                   m_valid_q, m_user_q, m_last_q;
    logic [CNT_WIDTH-1:0]   pix_cnt_q, red_cnt_q, stat_pix_q, stat_red_q;
    logic                   done_q, len_err_q;

    logic                   accept, sof;
    logic                   en_e;
    logic [1:0]             mode_e;
    logic [7:0]             thr_e;
    logic [CNT_WIDTH-1:0]   fp_e;
    logic [7:0]             r, g, b;
    logic                   r_ge, qual;
    logic [23:0]            px_out;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [CNT_WIDTH-1:0]   pix_cnt_d, red_cnt_d;
    logic                   unused_hi;

    assign unused_hi = ^s_axis_tdata[DATA_WIDTH-1:24];

    assign s_axis_tready = rdy_en_q & (~m_valid_q | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign sof           = accept & s_axis_tuser;

    // The start-of-frame beat already runs on the configuration it latches.
    assign en_e   = sof ? cfg_enable       : en_q;
    assign mode_e = sof ? cfg_mode         : mode_q;
    assign thr_e  = sof ? cfg_threshold    : thr_q;
    assign fp_e   = sof ? cfg_frame_pixels : fp_q;

    assign r    = s_axis_tdata[23:16];
    assign g    = s_axis_tdata[15:8];
    assign b    = s_axis_tdata[7:0];
    assign r_ge = (r >= thr_e);

    always_comb begin
        px_out = s_axis_tdata[23:0];
        qual   = r_ge;
        if (en_e) begin
            unique case (mode_e)
                2'b00: ;
                2'b01: px_out = {r, 16'h0000};
                2'b10: px_out = r_ge ? {r, 16'h0000} : 24'h000000;
                2'b11: begin
                    qual   = r_ge && (r > g) && (r > b);
                    px_out = qual ? 24'hFF0000 : 24'h000000;
                end
            endcase
        end
    end

    assign data_d    = DATA_WIDTH'(px_out);
    assign pix_cnt_d = sof ? CNT_WIDTH'(1)    : sat_inc(pix_cnt_q, 1'b1);
    assign red_cnt_d = sof ? CNT_WIDTH'(qual) : sat_inc(red_cnt_q, qual);

    // Output register stage and frame-tracking FSM
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            rdy_en_q   <= 1'b0;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            thr_q      <= 8'h00;
            fp_q       <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_user_q   <= 1'b0;
            m_last_q   <= 1'b0;
            pix_cnt_q  <= '0;
            red_cnt_q  <= '0;
            stat_pix_q <= '0;
            stat_red_q <= '0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            done_q   <= 1'b0;
            if (s_axis_tready) begin
                m_valid_q <= s_axis_tvalid;
                if (s_axis_tvalid) begin
                    m_data_q <= data_d;
                    m_user_q <= s_axis_tuser;
                    m_last_q <= s_axis_tlast;
                end
            end
            if (sof) begin
                en_q   <= cfg_enable;
                mode_q <= cfg_mode;
                thr_q  <= cfg_threshold;
                fp_q   <= cfg_frame_pixels;
            end
            if (accept) begin
                if (sof && !cfg_enable) len_err_q <= 1'b0;
                // A second start inside a frame aborts it.
                if (sof && state_q == ACTIVE) len_err_q <= 1'b1;
                if (s_axis_tlast) begin
                    state_q <= IDLE;
                    if (sof || state_q == ACTIVE) begin
                        stat_pix_q <= pix_cnt_d;
                        stat_red_q <= red_cnt_d;
                        done_q     <= 1'b1;
                        if (pix_cnt_d != fp_e) len_err_q <= 1'b1;
                    end else begin
                        len_err_q <= 1'b1;
                    end
                end else if (sof) begin
                    state_q   <= ACTIVE;
                    pix_cnt_q <= pix_cnt_d;
                    red_cnt_q <= red_cnt_d;
                end else if (state_q == ACTIVE) begin
                    pix_cnt_q <= pix_cnt_d;
                    red_cnt_q <= red_cnt_d;
                end
            end
        end
    end

    assign m_axis_tdata     = m_data_q;
    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tuser     = m_user_q;
    assign m_axis_tlast     = m_last_q;
    assign stat_pixel_count = stat_pix_q;
    assign stat_red_count   = stat_red_q;
    assign stat_frame_done  = done_q;
    assign stat_len_error   = len_err_q;

endmodule
